// File: rtl/bisection_sequencer.sv
// Bisection sequencer: closed-loop search for the i_ref code that yields the
// desired Q. Each midpoint is driven onto i_ref, allowed to settle, measured
// (with a timeout), and the search bounds are narrowed around the target.
module bisection_sequencer #(
  parameter int BUS_WIDTH      = 10,
  parameter int TOL            = 1,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_ITER       = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [BUS_WIDTH-1:0] q_desired,
  input  logic [BUS_WIDTH-1:0] q_measured,
  input  logic                 meas_valid,
  output logic                 meas_start,
  output logic [BUS_WIDTH-1:0] i_ref,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic                 timeout_err,
  output logic [7:0]           iter_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_EVAL    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BUS_WIDTH-1:0] CODE_MAX     = '1;
  localparam logic [BUS_WIDTH-1:0] MID_INIT     = CODE_MAX >> 1;
  localparam logic [BUS_WIDTH-1:0] SPAN_MIN     = BUS_WIDTH'(1);
  localparam logic [BUS_WIDTH:0]   TOL_C        = (BUS_WIDTH + 1)'(TOL);
  localparam logic [SW-1:0]        SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]        TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]           MAX_ITER_C   = 8'(MAX_ITER);

  logic [2:0]           state;
  logic [BUS_WIDTH-1:0] lo;
  logic [BUS_WIDTH-1:0] hi;
  logic [BUS_WIDTH-1:0] q_tgt;
  logic [BUS_WIDTH-1:0] q_meas;
  logic [SW-1:0]        settle_cnt;
  logic [TW-1:0]        timeout_cnt;

  logic signed [BUS_WIDTH:0] diff;
  logic [BUS_WIDTH:0]        err_abs;
  logic                      within_tol;
  logic                      tgt_above;
  logic [BUS_WIDTH-1:0]      new_lo;
  logic [BUS_WIDTH-1:0]      new_hi;
  logic [BUS_WIDTH-1:0]      span;
  logic [BUS_WIDTH:0]        mid_sum;
  logic                      narrow;
  logic                      last_iter;

  // busy covers every state in which a run is actively in progress
  assign busy = (state == S_INIT) || (state == S_SETTLE) ||
                (state == S_MEASURE) || (state == S_EVAL);

  // Evaluation datapath: widened signed error and the narrowed bounds/midpoint
  always_comb begin
    diff       = $signed({1'b0, q_meas}) - $signed({1'b0, q_tgt});
    err_abs    = diff[BUS_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    within_tol = (err_abs <= TOL_C);
    tgt_above  = (q_tgt > q_meas);
    new_lo     = tgt_above ? i_ref : lo;
    new_hi     = tgt_above ? hi : i_ref;
    span       = new_hi - new_lo;
    narrow     = (span <= SPAN_MIN);
    mid_sum    = {1'b0, new_lo} + {1'b0, new_hi};
    last_iter  = ((iter_count + 8'd1) == MAX_ITER_C);
  end

  // Main sequencer: abort overrides everything, otherwise walk the search FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      lo          <= '0;
      hi          <= CODE_MAX;
      q_tgt       <= '0;
      q_meas      <= '0;
      i_ref       <= '0;
      settle_cnt  <= '0;
      timeout_cnt <= '0;
      meas_start  <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      timeout_err <= 1'b0;
      iter_count  <= '0;
    end else begin
      meas_start <= 1'b0;
      if (abort) begin
        state       <= S_IDLE;
        done        <= 1'b0;
        converged   <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
              state       <= S_INIT;
              done        <= 1'b0;
              converged   <= 1'b0;
              timeout_err <= 1'b0;
              iter_count  <= '0;
            end
          end
          S_INIT: begin
            lo         <= '0;
            hi         <= CODE_MAX;
            q_tgt      <= q_desired;
            i_ref      <= MID_INIT;
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end
          S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              meas_start  <= 1'b1;
              timeout_cnt <= '0;
              state       <= S_MEASURE;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          S_MEASURE: begin
            if (meas_valid) begin
              q_meas <= q_measured;
              state  <= S_EVAL;
            end else if (timeout_cnt == TIMEOUT_LAST) begin
              timeout_err <= 1'b1;
              state       <= S_ERROR;
            end else begin
              timeout_cnt <= timeout_cnt + 1'b1;
            end
          end
          S_EVAL: begin
            iter_count <= iter_count + 8'd1;
            if (within_tol) begin
              converged <= 1'b1;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              lo <= new_lo;
              hi <= new_hi;
              if (last_iter || narrow) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                i_ref      <= mid_sum[BUS_WIDTH:1];
                settle_cnt <= '0;
                state      <= S_SETTLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bisection_sequencer.sv
// Self-checking bench for bisection_sequencer: a plant answers each
// measurement trigger after three cycles, and an integer bisection model
// predicts the midpoint sequence and final status of every run.
module tb_bisection_sequencer;

  localparam int BW       = 10;
  localparam int TOL      = 1;
  localparam int SETTLE   = 4;
  localparam int TIMEOUT  = 64;
  localparam int MAX_ITER = 12;
  localparam int CODE_MAX = 1023;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [BW-1:0] q_desired;
  logic [BW-1:0] q_measured = '0;
  logic          meas_valid = 1'b0;
  logic          meas_start;
  logic [BW-1:0] i_ref;
  logic          busy;
  logic          done;
  logic          converged;
  logic          timeout_err;
  logic [7:0]    iter_count;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  int plant_mode   = 0;
  int pend         = 0;
  bit inject_valid = 1'b0;
  int ms_iref[$];
  int ms_cycle[$];
  int start_cycle;
  int end_cycle;

  int exp_seq[$];
  int exp_iref;
  int exp_conv;
  int exp_iters;

  bisection_sequencer #(
    .BUS_WIDTH(BW), .TOL(TOL), .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .q_desired(q_desired), .q_measured(q_measured), .meas_valid(meas_valid),
    .meas_start(meas_start), .i_ref(i_ref), .busy(busy), .done(done),
    .converged(converged), .timeout_err(timeout_err), .iter_count(iter_count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle index used for latency measurements
  always @(posedge clk) cycle <= cycle + 1;

  // Plant response: 0 = identity, 1 = never answers, 2 = saturates at 300
  function automatic int plant_q(input int code, input int mode);
    if (mode == 2) return (code < 300) ? code : 300;
    return code;
  endfunction

  // Plant and trigger monitor: logs every meas_start and answers 3 cycles later
  always @(negedge clk) begin
    bit fire;
    fire = 1'b0;
    if (meas_start) begin
      ms_iref.push_back(int'(i_ref));
      ms_cycle.push_back(cycle);
      pend = (plant_mode != 1) ? 3 : 0;
    end else if (pend > 0) begin
      pend = pend - 1;
      fire = (pend == 0);
    end
    meas_valid = fire || inject_valid;
    q_measured = BW'(plant_q(int'(i_ref), plant_mode));
  end

  // Reference: plain integer bisection over the full code range
  task automatic model_run(input int qd, input int mode);
    int lo;
    int hi;
    int mid;
    lo = 0;
    hi = CODE_MAX;
    mid = (lo + hi) / 2;
    exp_seq.delete();
    exp_conv = 0;
    exp_iters = 0;
    for (int it = 1; it <= MAX_ITER; it++) begin
      int q;
      int e;
      q = plant_q(mid, mode);
      e = (q > qd) ? q - qd : qd - q;
      exp_seq.push_back(mid);
      exp_iters = it;
      if (e <= TOL) begin
        exp_conv = 1;
        break;
      end
      if (qd > q) lo = mid;
      else hi = mid;
      if (hi - lo <= 1) break;
      mid = (lo + hi) / 2;
    end
    exp_iref = mid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int qd);
    @(negedge clk);
    ms_iref.delete();
    ms_cycle.delete();
    q_desired = BW'(qd);
    start = 1'b1;
    start_cycle = cycle;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (done || timeout_err) begin
        ok = 1'b1;
        end_cycle = cycle;
      end
    end
    checkOutput({tag, "_finished"}, 32'(ok), 1);
  endtask

  task automatic checkRun(input string tag);
    int lat;
    lat = (ms_cycle.size() > 0) ? ms_cycle[0] - start_cycle : -1;
    checkOutput({tag, "_done"}, 32'(done), 1);
    checkOutput({tag, "_conv"}, 32'(converged), exp_conv);
    checkOutput({tag, "_iref"}, 32'(i_ref), exp_iref);
    checkOutput({tag, "_iter"}, 32'(iter_count), exp_iters);
    checkOutput({tag, "_nstarts"}, ms_iref.size(), exp_seq.size());
    for (int k = 0; k < exp_seq.size() && k < ms_iref.size(); k++)
      checkOutput($sformatf("%s_mid%0d", tag, k), ms_iref[k], exp_seq[k]);
    checkOutput({tag, "_latency"}, lat, SETTLE + 2);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_tmo"}, 32'(timeout_err), 0);
  endtask

  task automatic waitMeasStart(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = meas_start;
    end
    checkOutput({tag, "_meas_start_seen"}, 32'(seen), 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    q_desired = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_iref", 32'(i_ref), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_iter", 32'(iter_count), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_meas_start", 32'(meas_start), 0);

    // Nominal search towards 700
    plant_mode = 0;
    applyStimulus(700);
    checkOutput("nom_busy_init", 32'(busy), 1);
    model_run(700, 0);
    waitDone("nom");
    checkRun("nom");
    checkOutput("nom_mid0_const", (ms_iref.size() > 0) ? ms_iref[0] : -1, 511);
    checkOutput("nom_mid1_const", (ms_iref.size() > 1) ? ms_iref[1] : -1, 767);
    checkOutput("nom_mid2_const", (ms_iref.size() > 2) ? ms_iref[2] : -1, 639);
    checkOutput("nom_mid3_const", (ms_iref.size() > 3) ? ms_iref[3] : -1, 703);
    checkOutput("nom_close", 32'((i_ref >= 699) && (i_ref <= 701)), 1);
    checkOutput("nom_iter_bound", 32'(iter_count <= 8'd10), 1);

    // Ignored inputs: start in INIT/SETTLE, meas_valid in SETTLE, q_desired change
    applyStimulus(700);
    #1;
    start = 1'b1;
    inject_valid = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    inject_valid = 1'b0;
    q_desired = BW'(100);
    model_run(700, 0);
    waitDone("ign");
    checkRun("ign");

    // Timeout: plant never answers
    plant_mode = 1;
    applyStimulus(500);
    waitDone("tmo");
    checkOutput("tmo_err", 32'(timeout_err), 1);
    checkOutput("tmo_delay", (ms_cycle.size() > 0) ? end_cycle - ms_cycle[0] : -1, TIMEOUT);
    checkOutput("tmo_done", 32'(done), 0);
    checkOutput("tmo_busy", 32'(busy), 0);
    checkOutput("tmo_iref", 32'(i_ref), 511);
    checkOutput("tmo_nstarts", ms_iref.size(), 1);
    plant_mode = 0;
    applyStimulus(300);
    checkOutput("tmo_restart_clear", 32'(timeout_err), 0);
    checkOutput("tmo_restart_busy", 32'(busy), 1);
    model_run(300, 0);
    waitDone("tmo_restart");
    checkRun("tmo_restart");

    // Unreachable target with a saturating plant
    plant_mode = 2;
    applyStimulus(900);
    model_run(900, 2);
    waitDone("sat");
    checkRun("sat");
    checkOutput("sat_conv_const", 32'(converged), 0);
    checkOutput("sat_iref_high", 32'(i_ref >= 10'd1021), 1);
    checkOutput("sat_iter_bound", 32'(iter_count <= 8'd12), 1);

    // Abort during MEASURE, late meas_valid, then restart towards 100
    plant_mode = 0;
    applyStimulus(400);
    waitMeasStart("abt");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abt_busy", 32'(busy), 0);
    checkOutput("abt_done", 32'(done), 0);
    checkOutput("abt_iref_hold", 32'(i_ref), 511);
    repeat (6) @(negedge clk);
    checkOutput("abt_late_iref", 32'(i_ref), 511);
    checkOutput("abt_late_busy", 32'(busy), 0);
    checkOutput("abt_late_iter", 32'(iter_count), 0);
    checkOutput("abt_nstarts", ms_iref.size(), 1);
    applyStimulus(100);
    model_run(100, 0);
    waitDone("abt_restart");
    checkRun("abt_restart");

    // Asynchronous reset in the middle of SETTLE
    applyStimulus(600);
    @(negedge clk);
    checkOutput("rst_pre_busy", 32'(busy), 1);
    checkOutput("rst_pre_iref", 32'(i_ref), 511);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_iref", 32'(i_ref), 0);
    checkOutput("rst_async_busy", 32'(busy), 0);
    checkOutput("rst_async_iter", 32'(iter_count), 0);
    checkOutput("rst_async_flags", 32'({done, converged, timeout_err, meas_start}), 0);
    #1;
    rst = 1'b0;
    ms_iref.delete();
    ms_cycle.delete();
    repeat (20) @(negedge clk);
    checkOutput("rst_no_meas_start", ms_iref.size(), 0);
    checkOutput("rst_idle_busy", 32'(busy), 0);

    // Randomised targets
    for (int r = 0; r < 6; r++) begin
      int qd;
      qd = int'($urandom_range(0, CODE_MAX));
      plant_mode = 0;
      applyStimulus(qd);
      model_run(qd, 0);
      waitDone($sformatf("rnd%0d", r));
      checkRun($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bisection_sequencer.md
Name: bisection_sequencer

Overview:
- Closed-loop calibration sequencer that searches for the i_ref code giving the desired Q.
- Holds the search bounds and the midpoint.
- For each midpoint it waits for the analog front-end to settle, triggers a measurement, waits for the result with a timeout, and narrows the bounds.
- Sits between the measurement block (meas_start/meas_valid/q_measured) and the current-reference DAC (i_ref); reports done/converged/error status to the top-level control.

Parameters:
- BUS_WIDTH, 10: width of i_ref, q_desired and q_measured.
- TOL, 1: convergence tolerance; converged when |q_measured - q_desired| <= TOL.
- SETTLE_CYCLES, 16: clk cycles to wait after an i_ref change before triggering a measurement (>=1).
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for meas_valid after meas_start (>=1).
- MAX_ITER, 12: maximum number of evaluations per run (1..255).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: begin a search run; sampled only in IDLE, DONE or ERROR.
- abort, input, 1: terminate the current run; return to IDLE.
- q_desired, input, BUS_WIDTH: target Q code, unsigned; sampled once in INIT.
- q_measured, input, BUS_WIDTH: measured Q code, unsigned; valid when meas_valid=1.
- meas_valid, input, 1: one-cycle strobe from the measurement block.
- meas_start, output, 1: one-cycle measurement trigger.
- i_ref, output, BUS_WIDTH: current-reference code (registered midpoint).
- busy, output, 1: high in INIT, SETTLE, MEASURE and EVAL.
- done, output, 1: run finished normally; held until the next start or abort.
- converged, output, 1: valid while done=1; 1 means the tolerance was met.
- timeout_err, output, 1: measurement timed out; held until start or abort.
- iter_count, output, 8: number of completed evaluations in the current or last run.

Behaviour:
- Reset: state=IDLE; lo=0, hi=2^BUS_WIDTH-1; i_ref=0; meas_start, busy, done, converged, timeout_err=0; iter_count=0; all counters=0.
- States: IDLE, INIT, SETTLE, MEASURE, EVAL, DONE, ERROR.
- IDLE, DONE, ERROR: start=1 -> INIT. Entering INIT clears done, converged, timeout_err and iter_count.
- INIT (1 cycle):
  - lo=0, hi=2^BUS_WIDTH-1.
  - Capture q_desired into q_tgt.
  - i_ref <= (lo+hi)>>1, i.e. 511 for BUS_WIDTH=10.
  - -> SETTLE.
- SETTLE:
  - Counter runs from 0; after SETTLE_CYCLES cycles in SETTLE -> MEASURE.
- MEASURE:
  - meas_start=1 in the first MEASURE cycle only.
  - Timeout counter starts with that cycle.
  - meas_valid=1: capture q_measured -> EVAL. meas_valid in the same cycle as meas_start is accepted.
  - TIMEOUT_CYCLES cycles without meas_valid: timeout_err=1 -> ERROR.
- EVAL (1 cycle):
  - Error: err = |q_meas - q_tgt|, computed signed at BUS_WIDTH+1 bits before taking the absolute value. No wrap: err(0, 1023) = 1023.
  - iter_count increments by 1.
  - err <= TOL: converged=1, done=1 -> DONE. i_ref is unchanged.
  - Otherwise, if q_tgt > q_meas: lo <= i_ref. Else: hi <= i_ref.
  - Termination: if iter_count+1 == MAX_ITER, or the new hi-lo <= 1 -> DONE with converged=0.
  - Otherwise: i_ref <= (new lo + new hi)>>1, sum computed at BUS_WIDTH+1 bits (no overflow) -> SETTLE.
- DONE and ERROR: i_ref holds its final value.
- Latency: start seen in cycle N -> INIT in N+1 -> SETTLE from N+2 -> meas_start in cycle N+2+SETTLE_CYCLES.
- Ignored inputs:
  - meas_valid outside MEASURE is ignored.
  - start in INIT, SETTLE, MEASURE or EVAL is ignored.
- Abort:
  - abort=1 in any state -> IDLE next cycle; abort has priority over start and meas_valid.
  - Clears busy, done, converged and timeout_err. i_ref and iter_count hold.
  - A meas_valid arriving after abort is ignored.
- Reset mid-run: immediate return to the reset values listed above; no meas_start is issued.
- q_desired changes during a run have no effect, because q_tgt is latched in INIT.

Test Plan:
BUS_WIDTH=10, TOL=1, SETTLE_CYCLES=4, TIMEOUT_CYCLES=64, MAX_ITER=12. The plant model returns q_measured=i_ref with meas_valid 3 cycles after meas_start.
- Nominal search, q_desired=700:
  - i_ref sequence 511, 767, 639, 703, ...
  - Expect done=1, converged=1, |i_ref-700| <= 1, iter_count <= 10.
  - Expect exactly one meas_start per iteration.
  - The first meas_start is 6 cycles after start.
- Timeout: plant never asserts meas_valid -> timeout_err=1 exactly 64 cycles after meas_start; state ERROR, done=0, busy=0. A subsequent start clears timeout_err.
- Unreachable target: plant saturates at q=min(i_ref,300), q_desired=900 -> done=1, converged=0, i_ref >= 1021, iter_count <= 12.
- Abort during MEASURE: busy=0 next cycle; a late meas_valid does not change i_ref. A restart with q_desired=100 converges to |i_ref-100| <= 1.
- Asynchronous reset asserted mid-SETTLE: all outputs return to their reset values without waiting for a clk edge. No meas_start is issued afterward until a new start.
- Ignored inputs: start pulsed while busy has no effect; meas_valid pulsed during SETTLE does not advance the state; q_desired changed mid-run does not change the result.
